// File: rtl/mem_resp.sv
// Single-port word memory behind a req/ack handshake with a fixed number of
// wait states. Each transaction is captured in IDLE, waits WAIT cycles, and
// completes in RESP with a one-cycle ack, optional err and registered rdata.
module mem_resp #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];

    logic [31:0] rdata_q;
    logic        ack_q;
    logic        err_q;

    logic          t_we;
    logic [15:0]   t_addr;
    logic [31:0]   t_wdata;
    logic          t_in_range;
    logic [AW-1:0] t_idx;
    logic          resp_enter;

    // Transaction view: with WAIT=0 RESP is entered on the capture edge itself,
    // so in IDLE the live inputs stand in for the not-yet-captured registers.
    always_comb begin
        t_we       = we_q;
        t_addr     = addr_q;
        t_wdata    = wdata_q;
        if (state_q == StIdle) begin
            t_we    = we;
            t_addr  = addr;
            t_wdata = wdata;
        end
        t_in_range = ({16'h0000, t_addr} < DEPTH);
        t_idx      = t_addr[AW-1:0];
        resp_enter = (state_d == StResp);
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // <= guards against a zero count ever stalling the FSM.
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    cnt_d   = 4'd0;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 32'h0000_0000;
        end else if (state_q == StIdle && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Response registers, loaded on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            ack_q <= resp_enter;
            err_q <= resp_enter && !t_in_range;
            if (resp_enter && !t_we && t_in_range) begin
                rdata_q <= mem[t_idx];
            end
        end
    end

    // Storage is never cleared; a reset edge blocks any pending write.
    always_ff @(posedge clk) begin
        if (rst_f && resp_enter && t_we && t_in_range) begin
            mem[t_idx] <= t_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: four instances with WAIT = 2, 0, 3, 1.
module tb_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a   [4];
    logic        req_a   [4];
    logic        we_a    [4];
    logic [15:0] addr_a  [4];
    logic [31:0] wdata_a [4];
    logic [31:0] rdata_a [4];
    logic        ack_a   [4];
    logic        err_a   [4];
    logic        busy_a  [4];

    // Instance 0: WAIT=2, 1: WAIT=0, 2: WAIT=3, 3: WAIT=1.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_resp #(
            .DEPTH(256),
            .WAIT ((g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 3 : 1)
        ) u_dut (
            .clk  (clk),
            .rst_f(rst_a[g]),
            .req  (req_a[g]),
            .we   (we_a[g]),
            .addr (addr_a[g]),
            .wdata(wdata_a[g]),
            .rdata(rdata_a[g]),
            .ack  (ack_a[g]),
            .err  (err_a[g]),
            .busy (busy_a[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction; after capture the inputs are scrambled and req dropped.
    task automatic do_txn(input int i, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd, input string tag);
        int lat;
        int nbusy;
        req_a[i]   = 1'b1;
        we_a[i]    = w;
        addr_a[i]  = a;
        wdata_a[i] = d;
        tick;
        req_a[i]   = 1'b0;
        we_a[i]    = ~w;
        addr_a[i]  = a + 16'd2;
        wdata_a[i] = 32'h0000_0000;
        lat   = 1;
        nbusy = 0;
        while (!ack_a[i] && lat < 40) begin
            if (busy_a[i]) nbusy++;
            tick;
            lat++;
        end
        if (busy_a[i]) nbusy++;
        check_val({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "/err"}, {31'd0, err_a[i]}, {31'd0, exp_err});
        check_val({tag, "/rdata"}, rdata_a[i], exp_rd);
        check_val({tag, "/busy_cycles"}, 32'(nbusy), 32'(exp_lat));
        tick;
        check_val({tag, "/ack_after"}, {31'd0, ack_a[i]}, 32'd0);
        check_val({tag, "/err_after"}, {31'd0, err_a[i]}, 32'd0);
        check_val({tag, "/busy_after"}, {31'd0, busy_a[i]}, 32'd0);
    endtask

    logic [15:0] ba [4];
    logic [31:0] bd [4];

    initial begin
        int nack;
        int lat;
        int last;
        ba = '{16'h0010, 16'h0011, 16'h0020, 16'h003F};
        bd = '{32'h1111_0010, 32'h2222_0011, 32'h3333_0020, 32'h4444_003F};

        for (int i = 0; i < 4; i++) begin
            rst_a[i]   = 1'b0;
            req_a[i]   = 1'b0;
            we_a[i]    = 1'b0;
            addr_a[i]  = 16'h0000;
            wdata_a[i] = 32'h0000_0000;
        end
        tick;
        tick;
        for (int i = 0; i < 4; i++) begin
            check_val("rst/ack", {31'd0, ack_a[i]}, 32'd0);
            check_val("rst/err", {31'd0, err_a[i]}, 32'd0);
            check_val("rst/busy", {31'd0, busy_a[i]}, 32'd0);
            check_val("rst/rdata", rdata_a[i], 32'h0000_0000);
            rst_a[i] = 1'b1;
        end
        tick;

        // WAIT=2: write/read, out-of-range handling.
        do_txn(0, 1'b1, 16'h0005, 32'hCAFE_0001, 3, 1'b0, 32'h0000_0000, "w2_wr5");
        do_txn(0, 1'b0, 16'h0005, 32'h0000_0000, 3, 1'b0, 32'hCAFE_0001, "w2_rd5");
        do_txn(0, 1'b1, 16'h0000, 32'hA5A5_0000, 3, 1'b0, 32'hCAFE_0001, "w2_wr0");
        do_txn(0, 1'b1, 16'h0100, 32'h1234_5678, 3, 1'b1, 32'hCAFE_0001, "w2_wr_oor");
        do_txn(0, 1'b0, 16'h0000, 32'h0000_0000, 3, 1'b0, 32'hA5A5_0000, "w2_rd0");
        do_txn(0, 1'b0, 16'hFFFF, 32'h0000_0000, 3, 1'b1, 32'hA5A5_0000, "w2_rd_oor");

        // WAIT=2: reset during WAIT aborts a write to addr 3.
        do_txn(0, 1'b1, 16'h0003, 32'h0000_0033, 3, 1'b0, 32'hA5A5_0000, "w2_wr3");
        req_a[0]   = 1'b1;
        we_a[0]    = 1'b1;
        addr_a[0]  = 16'h0003;
        wdata_a[0] = 32'hDEAD_BEEF;
        tick;
        rst_a[0] = 1'b0;
        tick;
        rst_a[0] = 1'b0;
        req_a[0] = 1'b0;
        check_val("w2_rst/busy", {31'd0, busy_a[0]}, 32'd0);
        check_val("w2_rst/ack", {31'd0, ack_a[0]}, 32'd0);
        check_val("w2_rst/rdata", rdata_a[0], 32'h0000_0000);
        rst_a[0] = 1'b1;
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (ack_a[0]) nack++;
        end
        check_val("w2_rst/no_ack", 32'(nack), 32'd0);
        do_txn(0, 1'b0, 16'h0003, 32'h0000_0000, 3, 1'b0, 32'h0000_0033, "w2_rd3");

        // WAIT=0: single-cycle response.
        do_txn(1, 1'b1, 16'h0005, 32'h5A5A_0005, 1, 1'b0, 32'h0000_0000, "w0_wr5");
        do_txn(1, 1'b0, 16'h0005, 32'h0000_0000, 1, 1'b0, 32'h5A5A_0005, "w0_rd5");

        // WAIT=3: post-capture input changes are ignored.
        do_txn(2, 1'b1, 16'h0009, 32'h9999_0009, 4, 1'b0, 32'h0000_0000, "w3_wr9");
        do_txn(2, 1'b1, 16'h0007, 32'h0000_7007, 4, 1'b0, 32'h0000_0000, "w3_wr7");
        do_txn(2, 1'b0, 16'h0009, 32'h0000_0000, 4, 1'b0, 32'h9999_0009, "w3_rd9");
        do_txn(2, 1'b0, 16'h0007, 32'h0000_0000, 4, 1'b0, 32'h0000_7007, "w3_rd7");

        // WAIT=1: prefill, then four back-to-back reads with req held high.
        for (int k = 0; k < 4; k++) begin
            do_txn(3, 1'b1, ba[k], bd[k], 2, 1'b0, 32'h0000_0000, "w1_fill");
        end
        req_a[3]  = 1'b1;
        we_a[3]   = 1'b0;
        addr_a[3] = ba[0];
        last      = cyc;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            while (!ack_a[3] && lat < 20) begin
                tick;
                lat++;
            end
            check_val("w1_b2b/ack", {31'd0, ack_a[3]}, 32'd1);
            check_val("w1_b2b/rdata", rdata_a[3], bd[k]);
            check_val("w1_b2b/spacing", 32'(cyc - last), (k == 0) ? 32'd2 : 32'd3);
            last = cyc;
            if (k < 3) addr_a[3] = ba[k + 1];
            else req_a[3] = 1'b0;
            tick;
        end
        tick;
        check_val("w1_b2b/idle", {31'd0, busy_a[3]}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words held; power of two, 2..65536.
REQ-002 Parameter WAIT, default 2, wait-state cycles inserted before acknowledge; range 0..15.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst_f  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-005 req  input  1  initiator request; addr, we and wdata are valid while high.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  16  word address.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data, registered.
REQ-010 ack  output  1  one-cycle transaction-complete pulse, registered.
REQ-011 err  output  1  address-out-of-range flag, valid only while ack=1.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP, with a 4-bit wait counter.
REQ-014 In IDLE with req=1 at posedge, the block SHALL capture addr, we and wdata into internal registers and go to WAIT with counter=WAIT, or go directly to RESP if WAIT=0.
REQ-015 In IDLE with req=0, the block SHALL remain in IDLE.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the block SHALL go to RESP on the edge where the counter equals 1.
REQ-017 RESP SHALL last exactly one cycle, with ack=1, followed unconditionally by IDLE.
REQ-018 Latency: ack SHALL be high in cycle WAIT+1 after the capture edge (capture edge = cycle 0).
REQ-019 A write SHALL update memory on the edge entering RESP, using the captured address and data.
REQ-020 A read SHALL load rdata on the edge entering RESP.
REQ-021 rdata SHALL hold its value until the next completed read or reset; writes SHALL NOT change rdata.
REQ-022 An address with captured addr >= DEPTH SHALL suppress the write, leave rdata unchanged and assert err=1 together with ack.
REQ-023 err SHALL be 0 whenever ack=0.
REQ-024 Changes on req, addr, we or wdata after capture SHALL be ignored, and the captured transaction SHALL complete; dropping req mid-transaction SHALL NOT abort it.
REQ-025 The initiator SHALL deassert req in the cycle after ack; req=1 in IDLE is a new transaction, giving back-to-back transactions without gaps.
REQ-026 A write followed by a read of the same address SHALL return the newly written data.
REQ-027 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.

Reset
REQ-028 rst_f=0 at posedge SHALL force IDLE, counter=0, ack=0, err=0, busy=0 and rdata=32'h0000_0000.
REQ-029 Reset SHALL NOT clear memory contents.
REQ-030 Reset during WAIT or RESP SHALL abort the transaction: no write after the reset edge and no ack.
REQ-031 Reset SHALL dominate req in the same cycle.
REQ-032 Outputs SHALL NOT change asynchronously on rst_f.

Verification
REQ-033 WAIT=2: write addr=5, wdata=32'hCAFE_0001, then read addr=5 -> each ack in cycle 3 after capture; read rdata=32'hCAFE_0001; err=0.
REQ-034 WAIT=0: read addr=5 -> ack in cycle 1 after capture; busy high for exactly 1 cycle.
REQ-035 DEPTH=256: write addr=16'h0100 with 32'h1234_5678, then read addr=0 -> first ack has err=1; addr 0 content unchanged; rdata unchanged by the failed write.
REQ-036 WAIT=3: capture a write addr=7, then drop req and change addr to 9 and wdata to 0 -> ack in cycle 4; memory[7] updated; memory[9] untouched.
REQ-037 WAIT=2: rst_f=0 for one cycle during WAIT of a write to addr=3 -> no ack; busy=0 after the reset edge; memory[3] retains its old value; next request behaves normally.
REQ-038 req held high continuously with 4 reads at WAIT=1 -> 4 acks, each 3 cycles apart (capture, wait, resp), with correct rdata in each.
